// File: rtl/spdif_bmc_frame_tx_pkg.sv
// Shared constants for the S/PDIF frame transmitter: preamble cell patterns,
// subframe slot map, channel-status layout and small coding helpers.
package spdif_bmc_frame_tx_pkg;

    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam int SLOT_AUDIO_LSB   = 4;
    localparam int SLOT_V           = 28;
    localparam int SLOT_U           = 29;
    localparam int SLOT_C           = 30;
    localparam int SLOT_P           = 31;

    localparam int CS_BIT_CONSUMER  = 0;
    localparam int CS_BIT_COPY      = 2;
    localparam int CS_BIT_FS        = 24;
    localparam int CS_BIT_WORDLEN   = 32;
    localparam int FRAMES_PER_BLOCK = 192;

    typedef enum logic [1:0] {
        PRE_KIND_B = 2'd0,
        PRE_KIND_M = 2'd1,
        PRE_KIND_W = 2'd2
    } pre_kind_e;

    function automatic logic [7:0] preamble_cells(input pre_kind_e kind);
        logic [7:0] pat;
        case (kind)
            PRE_KIND_B: pat = PRE_B;
            PRE_KIND_M: pat = PRE_M;
            PRE_KIND_W: pat = PRE_W;
            default:    pat = PRE_M;
        endcase
        return pat;
    endfunction

    // Even parity over slots 4..30 (audio, V, U, C) gives the P slot value.
    function automatic logic even_parity(input logic [26:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/spdif_chstat_gen.sv
// Consumer channel-status bit for a given frame of the 192-frame block.
// Code nibbles are read MSB first: CS_FS_CODE[3] lands in block bit 24.
module spdif_chstat_gen
    import spdif_bmc_frame_tx_pkg::*;
#(
    parameter logic [3:0] CS_FS_CODE      = 4'b0100,
    parameter logic [3:0] CS_WORDLEN_CODE = 4'b1011
) (
    input  logic [7:0] frame_idx,
    output logic       cs_bit
);

    logic [1:0] nib_pos_s;

    assign nib_pos_s = 2'd3 - frame_idx[1:0];

    // One status bit per frame; bit 0 (consumer) and all unlisted bits stay 0.
    always_comb begin
        cs_bit = 1'b0;
        if (frame_idx == 8'(CS_BIT_COPY)) begin
            cs_bit = 1'b1;
        end else if (frame_idx[7:2] == 6'(CS_BIT_FS / 4)) begin
            cs_bit = CS_FS_CODE[nib_pos_s];
        end else if (frame_idx[7:2] == 6'(CS_BIT_WORDLEN / 4)) begin
            cs_bit = CS_WORDLEN_CODE[nib_pos_s];
        end else begin
            cs_bit = 1'b0;
        end
    end

endmodule

// File: rtl/spdif_bmc_frame_tx.sv
// IEC 60958 consumer S/PDIF transmitter: frame/block timing, one-deep sample
// buffer, subframe assembly and biphase-mark line coding.
module spdif_bmc_frame_tx
    import spdif_bmc_frame_tx_pkg::*;
#(
    parameter int         CLK_PER_HALFCELL = 2,
    parameter logic [3:0] CS_FS_CODE       = 4'b0100,
    parameter logic [3:0] CS_WORDLEN_CODE  = 4'b1011
) (
    input  logic        MCLK_i,
    input  logic        RST_i,
    input  logic        SPDIF_en,
    input  logic [23:0] PDATA_LEFT_i,
    input  logic [23:0] PDATA_RIGHT_i,
    input  logic        PDATA_VALID_i,
    output logic        SPDIF_o,
    output logic        FRAME_START_o,
    output logic        UNDERRUN_o,
    output logic        OVERRUN_o
);

    localparam int            PW         = (CLK_PER_HALFCELL > 1) ? $clog2(CLK_PER_HALFCELL) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_HALFCELL - 1);

    logic [PW-1:0] presc_r;
    logic [6:0]    cell_r;
    logic [7:0]    frame_r;
    logic          en_d_r;
    logic          pend_full_r;
    logic [23:0]   pend_l_r, pend_r_r, act_l_r, act_r_r;
    logic [27:0]   sub_bits_r;
    logic          pre_lvl_r, line_r, frame_start_r, underrun_r, overrun_r;

    logic          cell_start_s, xfer_s, sub_start_s, en_rise_s, en_fall_s, cs_bit_s;
    logic          pre_ref_s, line_nxt_s;
    logic [4:0]    slot_s;
    logic [23:0]   sub_audio_s;
    logic [27:0]   sub_load_s;
    logic [7:0]    pre_pat_s;
    pre_kind_e     pre_kind_s;

    assign cell_start_s = SPDIF_en && (presc_r == '0);
    assign xfer_s       = cell_start_s && (cell_r == 7'd0);
    assign sub_start_s  = cell_start_s && (cell_r[5:0] == 6'd0);
    assign en_rise_s    = SPDIF_en && !en_d_r;
    assign en_fall_s    = en_d_r && !SPDIF_en;
    assign slot_s       = cell_r[5:1];

    spdif_chstat_gen #(
        .CS_FS_CODE      (CS_FS_CODE),
        .CS_WORDLEN_CODE (CS_WORDLEN_CODE)
    ) u_chstat (
        .frame_idx (frame_r),
        .cs_bit    (cs_bit_s)
    );

    // Subframe contents and next line level for the cell about to start.
    always_comb begin
        sub_audio_s = act_r_r;
        pre_kind_s  = PRE_KIND_W;
        if (cell_r[6]) begin
            sub_audio_s = act_r_r;
            pre_kind_s  = PRE_KIND_W;
        end else begin
            // Left audio is captured on the same edge the active pair is refreshed.
            sub_audio_s = pend_full_r ? pend_l_r : act_l_r;
            pre_kind_s  = (frame_r == 8'd0) ? PRE_KIND_B : PRE_KIND_M;
        end
        sub_load_s      = {1'b0, cs_bit_s, 1'b0, 1'b0, sub_audio_s};
        sub_load_s[27]  = even_parity(sub_load_s[26:0]);
        pre_pat_s       = preamble_cells(pre_kind_s);
        pre_ref_s       = (cell_r[5:0] == 6'd0) ? line_r : pre_lvl_r;
        if (slot_s < 5'(SLOT_AUDIO_LSB)) begin
            line_nxt_s = pre_pat_s[3'd7 - cell_r[2:0]] ^ pre_ref_s;
        end else if (!cell_r[0]) begin
            line_nxt_s = ~line_r;
        end else begin
            line_nxt_s = line_r ^ sub_bits_r[0];
        end
    end

    // Halfcell prescaler, cell and frame counters; held at zero while idle.
    always_ff @(posedge MCLK_i or posedge RST_i) begin
        if (RST_i) begin
            presc_r <= '0;
            cell_r  <= 7'd0;
            frame_r <= 8'd0;
        end else if (!SPDIF_en) begin
            presc_r <= '0;
            cell_r  <= 7'd0;
            frame_r <= 8'd0;
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= '0;
            cell_r  <= cell_r + 7'd1;
            if (cell_r == 7'd127) begin
                frame_r <= (frame_r == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_r + 8'd1;
            end
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Line driver: preamble cells, then one slot bit per pair of cells.
    always_ff @(posedge MCLK_i or posedge RST_i) begin
        if (RST_i) begin
            line_r        <= 1'b0;
            pre_lvl_r     <= 1'b0;
            sub_bits_r    <= 28'd0;
            frame_start_r <= 1'b0;
        end else if (!SPDIF_en) begin
            line_r        <= 1'b0;
            pre_lvl_r     <= 1'b0;
            sub_bits_r    <= 28'd0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= xfer_s;
            if (cell_start_s) begin
                line_r <= line_nxt_s;
                if (sub_start_s) begin
                    pre_lvl_r  <= line_r;
                    sub_bits_r <= sub_load_s;
                end else if (cell_r[0] && (slot_s >= 5'(SLOT_AUDIO_LSB))) begin
                    sub_bits_r <= sub_bits_r >> 1;
                end
            end
        end
    end

    // Pending/active sample buffers; a pair may be primed while idle.
    always_ff @(posedge MCLK_i or posedge RST_i) begin
        if (RST_i) begin
            pend_full_r <= 1'b0;
            pend_l_r    <= 24'd0;
            pend_r_r    <= 24'd0;
            act_l_r     <= 24'd0;
            act_r_r     <= 24'd0;
        end else if (en_fall_s) begin
            pend_full_r <= 1'b0;
        end else if (xfer_s) begin
            if (pend_full_r) begin
                act_l_r <= pend_l_r;
                act_r_r <= pend_r_r;
            end
            pend_full_r <= PDATA_VALID_i;
            if (PDATA_VALID_i) begin
                pend_l_r <= PDATA_LEFT_i;
                pend_r_r <= PDATA_RIGHT_i;
            end
        end else if (PDATA_VALID_i) begin
            pend_full_r <= 1'b1;
            pend_l_r    <= PDATA_LEFT_i;
            pend_r_r    <= PDATA_RIGHT_i;
        end
    end

    // Sticky status flags; a new event on the enable edge wins over the clear.
    always_ff @(posedge MCLK_i or posedge RST_i) begin
        if (RST_i) begin
            en_d_r     <= 1'b0;
            underrun_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            en_d_r <= SPDIF_en;
            if (xfer_s && !pend_full_r) begin
                underrun_r <= 1'b1;
            end else if (en_rise_s) begin
                underrun_r <= 1'b0;
            end
            if (PDATA_VALID_i && pend_full_r && !xfer_s && !en_fall_s) begin
                overrun_r <= 1'b1;
            end else if (en_rise_s) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign SPDIF_o       = line_r;
    assign FRAME_START_o = frame_start_r;
    assign UNDERRUN_o    = underrun_r;
    assign OVERRUN_o     = overrun_r;

endmodule

// File: tb/tb_spdif_bmc_frame_tx.sv
// Randomized scoreboard bench: stimulus pushes the expected frame contents,
// a monitor decodes the BMC line independently and pops/compares.
module tb_spdif_bmc_frame_tx;

    logic        MCLK_i = 1'b0;
    logic        RST_i;
    logic        SPDIF_en;
    logic [23:0] PDATA_LEFT_i;
    logic [23:0] PDATA_RIGHT_i;
    logic        PDATA_VALID_i;
    logic        SPDIF_o;
    logic        FRAME_START_o;
    logic        UNDERRUN_o;
    logic        OVERRUN_o;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          idx;
    } frame_exp_t;

    frame_exp_t  sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_picks  = 0;
    int          decoded  = 0;
    longint      cyc      = 0;
    longint      last_fs  = 0;
    logic        mon_cells [128];

    // Reference model state: last strobed pair, pair currently on air, flags.
    logic [23:0] m_l, m_r, m_prev_l, m_prev_r;
    int          m_fresh, m_idx;
    logic        m_under, m_over;

    spdif_bmc_frame_tx #(.CLK_PER_HALFCELL(2)) dut (
        .MCLK_i        (MCLK_i),
        .RST_i         (RST_i),
        .SPDIF_en      (SPDIF_en),
        .PDATA_LEFT_i  (PDATA_LEFT_i),
        .PDATA_RIGHT_i (PDATA_RIGHT_i),
        .PDATA_VALID_i (PDATA_VALID_i),
        .SPDIF_o       (SPDIF_o),
        .FRAME_START_o (FRAME_START_o),
        .UNDERRUN_o    (UNDERRUN_o),
        .OVERRUN_o     (OVERRUN_o)
    );

    always #5 MCLK_i = ~MCLK_i;
    always @(posedge MCLK_i) cyc <= cyc + 1;

    function automatic logic cs_exp(input int n);
        case (n)
            2, 25, 32, 34, 35: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic finish_now();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic pick(output logic [23:0] l, output logic [23:0] r);
        if (n_picks < 4) begin
            l = 24'h000001;
            r = 24'h800000;
        end else begin
            l = 24'($urandom());
            r = 24'($urandom());
        end
        n_picks++;
    endtask

    task automatic strobe(input logic [23:0] l, input logic [23:0] r);
        PDATA_LEFT_i  = l;
        PDATA_RIGHT_i = r;
        PDATA_VALID_i = 1'b1;
        @(negedge MCLK_i);
        PDATA_VALID_i = 1'b0;
        m_l = l;
        m_r = r;
        m_fresh++;
    endtask

    // Next frame carries the newest pair strobed since the last frame, else repeats.
    task automatic push_next();
        frame_exp_t e;
        if (m_fresh == 0) m_under = 1'b1;
        else begin
            m_prev_l = m_l;
            m_prev_r = m_r;
        end
        if (m_fresh >= 2) m_over = 1'b1;
        e.l = m_prev_l;
        e.r = m_prev_r;
        e.idx = m_idx % 192;
        m_idx++;
        sb_q.push_back(e);
        m_fresh = 0;
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (FRAME_START_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge MCLK_i);
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL frame_start_timeout: got no FRAME_START_o in 400 cycles, required one");
            finish_now();
        end
    endtask

    task automatic run_frames(input int nf, input bit specials);
        for (int f = 0; f < nf; f++) begin
            bit ok;
            int ns;
            bit coinc;
            logic [23:0] l, r;
            wait_fs(ok);
            check("underrun_flag", UNDERRUN_o, m_under);
            check("overrun_flag", OVERRUN_o, m_over);
            if (f > 0) check("frame_period", cyc - last_fs, 64'd256);
            last_fs = cyc;
            ns = 1;
            coinc = 1'b0;
            if (specials) begin
                case (f)
                    5:       coinc = 1'b1;
                    6:       ns = 0;
                    10:      ns = 0;
                    30:      ns = 2;
                    default: ;
                endcase
            end
            repeat (40) @(negedge MCLK_i);
            for (int s = 0; s < ns; s++) begin
                pick(l, r);
                strobe(l, r);
            end
            repeat (254 - 40 - ns) @(negedge MCLK_i);
            push_next();
            if (coinc) begin
                @(negedge MCLK_i);
                pick(l, r);
                strobe(l, r);
            end
        end
    endtask

    task automatic decode_frame(input logic lvl0);
        frame_exp_t  e;
        logic [31:0] bits;
        logic [7:0]  pre, pre_exp;
        logic        ref_lvl;
        bit          bnd_ok;
        int          base;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL sb_empty: got 0 expected entries, required at least 1");
            return;
        end
        n_pass++;
        e = sb_q.pop_front();
        decoded++;
        for (int sub = 0; sub < 2; sub++) begin
            base = sub * 64;
            ref_lvl = (sub == 0) ? lvl0 : mon_cells[63];
            for (int i = 0; i < 8; i++) pre[7-i] = mon_cells[base+i] ^ ref_lvl;
            pre_exp = (sub == 1) ? 8'b11100100 : ((e.idx == 0) ? 8'b11101000 : 8'b11100010);
            check((sub == 1) ? "preamble_R" : "preamble_L", pre, pre_exp);
            bnd_ok = 1'b1;
            bits = 32'd0;
            for (int s = 4; s < 32; s++) begin
                if (mon_cells[base+2*s] == mon_cells[base+2*s-1]) bnd_ok = 1'b0;
                bits[s] = mon_cells[base+2*s] ^ mon_cells[base+2*s+1];
            end
            check("slot_edges", bnd_ok, 1'b1);
            check((sub == 1) ? "audio_R" : "audio_L", bits[27:4], (sub == 1) ? e.r : e.l);
            check("VU_bits", bits[29:28], 2'b00);
            check("C_bit", bits[30], cs_exp(e.idx));
            check("parity_even", ^bits[31:4], 1'b0);
        end
    endtask

    // Monitor: capture 128 half-cells after each FRAME_START_o, then decode.
    initial begin : monitor
        logic last_o;
        logic lvl0;
        bit   aborted;
        frame_exp_t junk;
        last_o = 1'b0;
        forever begin
            @(negedge MCLK_i);
            if (FRAME_START_o === 1'b1 && SPDIF_en === 1'b1) begin
                lvl0 = last_o;
                aborted = 1'b0;
                for (int c = 0; c < 256; c++) begin
                    if (c > 0) @(negedge MCLK_i);
                    if (SPDIF_en !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c % 2 == 0) mon_cells[c/2] = SPDIF_o;
                    last_o = SPDIF_o;
                end
                if (aborted) begin
                    if (sb_q.size() > 0) junk = sb_q.pop_front();
                    last_o = 1'b0;
                end else begin
                    decode_frame(lvl0);
                end
            end else begin
                last_o = SPDIF_o;
            end
        end
    end

    initial begin : stimulus
        bit ok;
        bit idle_bad;
        logic [23:0] l, r;
        RST_i = 1'b1;
        SPDIF_en = 1'b0;
        PDATA_VALID_i = 1'b0;
        PDATA_LEFT_i = 24'd0;
        PDATA_RIGHT_i = 24'd0;
        m_l = 24'd0; m_r = 24'd0; m_prev_l = 24'd0; m_prev_r = 24'd0;
        m_fresh = 0; m_idx = 0; m_under = 1'b0; m_over = 1'b0;
        repeat (3) @(negedge MCLK_i);
        check("rst_spdif", SPDIF_o, 1'b0);
        check("rst_frame_start", FRAME_START_o, 1'b0);
        check("rst_underrun", UNDERRUN_o, 1'b0);
        check("rst_overrun", OVERRUN_o, 1'b0);
        RST_i = 1'b0;
        idle_bad = 1'b0;
        repeat (1000) begin
            @(negedge MCLK_i);
            if (SPDIF_o !== 1'b0 || FRAME_START_o !== 1'b0) idle_bad = 1'b1;
        end
        check("idle_quiet", idle_bad, 1'b0);

        pick(l, r);
        strobe(l, r);
        push_next();
        SPDIF_en = 1'b1;
        run_frames(200, 1'b1);

        wait_fs(ok);
        repeat (20) @(negedge MCLK_i);
        SPDIF_en = 1'b0;
        @(negedge MCLK_i);
        check("line_low_after_disable", SPDIF_o, 1'b0);
        m_fresh = 0;
        idle_bad = 1'b0;
        repeat (40) begin
            @(negedge MCLK_i);
            if (SPDIF_o !== 1'b0 || FRAME_START_o !== 1'b0) idle_bad = 1'b1;
        end
        check("disabled_quiet", idle_bad, 1'b0);
        check("underrun_kept", UNDERRUN_o, m_under);
        check("overrun_kept", OVERRUN_o, m_over);

        pick(l, r);
        strobe(l, r);
        m_idx = 0;
        push_next();
        m_under = 1'b0;
        m_over = 1'b0;
        SPDIF_en = 1'b1;
        run_frames(4, 1'b0);
        wait_fs(ok);
        repeat (258) @(negedge MCLK_i);
        check("frames_decoded", decoded, 205);

        RST_i = 1'b1;
        @(negedge MCLK_i);
        check("midframe_rst_spdif", SPDIF_o, 1'b0);
        check("midframe_rst_frame_start", FRAME_START_o, 1'b0);
        check("midframe_rst_flags", {UNDERRUN_o, OVERRUN_o}, 2'b00);
        finish_now();
    end

endmodule
